seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU; successor to the fixed 2-bit combinational ALU/multiplier/divider set.
//  Supports add/sub/logic in 1 cycle and unsigned multiply/divide over W iterations (shift-add, restoring).
//  Valid/ready handshake on the input and output sides. Sits between the operand issue logic and the
//  result writeback. Divide-by-zero is flagged explicitly.
// PARAMETERS
//  W  8  operand width in bits (>=2); result is 2*W bits, remainder is W bits
// PORTS
//  clk          in   1    single clock; all state changes on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    operands/op presented
//  in_ready     out  1    block can accept an op (state IDLE)
//  a            in   W    operand A, unsigned
//  b            in   W    operand B, unsigned
//  op           in   3    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 PASS A
//  out_valid    out  1    result/remainder/div_by_zero are valid
//  out_ready    in   1    consumer takes result
//  result       out  2W   see width rules
//  remainder    out  W    DIV remainder; 0 for all other ops
//  div_by_zero  out  1    DIV with b==0; 0 for all other ops
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, remainder=0, div_by_zero=0, iteration cnt=0;
//   in_ready reads 1 while in IDLE, including during reset. Reset mid-operation discards it; no output.
//  FSM: IDLE -> CALC (accept MUL/DIV, b!=0) ; IDLE -> DONE (accept any other op or DIV b==0);
//   CALC -> DONE when counter reaches W-1 ; DONE -> IDLE when out_ready=1.
//  Accept = in_valid & in_ready on a rising edge; a, b, op captured in internal registers at accept.
//   Inputs need not be held after accept.
//  in_ready = (state==IDLE); no accept in CALC or DONE. Max throughput: 1 op per 2 cycles (1-cycle ops).
//  out_valid = (state==DONE). result/remainder/div_by_zero are stable while out_valid=1 & out_ready=0.
//  Latency (accept edge to out_valid=1): 1 cycle for ADD/SUB/logic/PASS/DIV-by-0; W+1 cycles for MUL/DIV.
//  Width rules (all unsigned, zero-extended to 2W):
//   ADD: result[W:0] = a+b (bit W = carry).
//   SUB: result[W-1:0] = (a-b) mod 2^W; result[W] = borrow (a<b).
//   AND/OR/XOR/PASS: result[W-1:0] = op(a,b) or a; upper bits 0.
//   MUL: result = a*b, full 2W product, one shift-add step per CALC cycle.
//   DIV: result[W-1:0] = a/b, remainder = a%b, one restoring step per CALC cycle.
//  DIV with b==0: no CALC; result=0, remainder=a, div_by_zero=1.
//  in_valid with an op while busy is ignored (not captured); the source must hold until in_ready.
//  Simultaneous out_ready in DONE and in_valid: DONE->IDLE this edge; new op accepted on the next edge.
//  Internal iteration counter is clog2(W) bits wide and cleared on entry to CALC.
// TESTING (W=8 unless stated)
//  ADD a=200 b=100 -> result=0x12C, out_valid 1 cycle after accept, remainder=0, dbz=0.
//  SUB a=5 b=7 -> result=0x01FE (low byte 0xFE, bit8 borrow=1); SUB 7-5 -> result=0x0002.
//  MUL a=255 b=255 -> result=0xFE01 exactly 9 cycles after accept; in_ready=0 throughout.
//  DIV a=200 b=7 -> result=28 rem=4 dbz=0 after 9 cycles; DIV a=13 b=0 -> result=0 rem=13 dbz=1 after 1 cycle.
//  Hold out_ready=0 for 5 cycles after MUL 12*11 -> result=132 stable, out_valid=1, in_ready=0;
//   out_ready=1 -> IDLE next edge.
//  Assert rst_n=0 mid-DIV (cycle 4) -> outputs 0 immediately; after release, ADD 1+1 -> result=2 normally.
//  Repeat random-operand sweep for W=4 and W=16 against a reference model.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: add/sub/logic/pass in one step, shift-add MUL and restoring DIV over W steps.
// Latency: 1 cycle for single-step ops and DIV by zero, W+1 cycles for MUL/DIV (accept to out_valid).
// Backpressure: accepts only when idle; the result is held stable in DONE until out_ready.
module seq_alu #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   b_r;
  logic           is_div;
  logic [2*W-1:0] p, p_nxt;
  logic [2*W-1:0] fast_res;
  logic [W:0]     sum_w, diff_w;
  logic [W:0]     mul_sum, div_t, div_diff;
  logic           accept, long_op, div_zero, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign div_zero  = (op == OP_DIV) && (b == '0);
  assign long_op   = (op == OP_MUL) || ((op == OP_DIV) && !div_zero);
  assign last      = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = long_op ? CALC : DONE;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fast_res = '0;
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD:  fast_res[W:0]   = sum_w;
      OP_SUB:  fast_res[W:0]   = diff_w;
      OP_AND:  fast_res[W-1:0] = a & b;
      OP_OR:   fast_res[W-1:0] = a | b;
      OP_XOR:  fast_res[W-1:0] = a ^ b;
      OP_PASS: fast_res[W-1:0] = a;
      default: fast_res        = '0;
    endcase
  end

  // p holds {accumulator, multiplier} for MUL and {partial remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, b_r} : '0);
    div_t    = p[2*W-1:W-1];
    div_diff = div_t - {1'b0, b_r};
    if (is_div) begin
      if (div_diff[W]) p_nxt = {div_t[W-1:0], p[W-2:0], 1'b0};
      else             p_nxt = {div_diff[W-1:0], p[W-2:0], 1'b1};
    end else begin
      p_nxt = {mul_sum, p[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      b_r         <= '0;
      is_div      <= 1'b0;
      p           <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_r    <= b;
            is_div <= (op == OP_DIV);
            p      <= {{W{1'b0}}, a};
            cnt    <= '0;
            if (div_zero) begin
              result      <= '0;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else if (!long_op) begin
              result      <= fast_res;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          p   <= p_nxt;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            div_by_zero <= 1'b0;
            if (is_div) begin
              result    <= {{W{1'b0}}, p_nxt[W-1:0]};
              remainder <= p_nxt[2*W-1:W];
            end else begin
              result    <= p_nxt;
              remainder <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu at W=8, plus random sweeps at W=4 and W=16.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  bit   sweep_go;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [7:0]  a, b, remainder;
  logic [2:0]  op;
  logic [15:0] result;

  seq_alu #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the architectural rules.
  function automatic void model(input int w, input int o, input longint av, input longint bv,
                                output longint res, output longint rem, output longint dbz,
                                output int lat);
    longint mask;
    mask = (longint'(1) << w) - 1;
    res = 0; rem = 0; dbz = 0; lat = 1;
    case (o)
      0: res = av + bv;
      1: res = ((av - bv) & mask) | ((av < bv) ? (longint'(1) << w) : 0);
      2: res = av & bv;
      3: res = av | bv;
      4: res = av ^ bv;
      5: begin res = av * bv; lat = w + 1; end
      6: if (bv == 0) begin rem = av; dbz = 1; end
         else begin res = av / bv; rem = av % bv; lat = w + 1; end
      default: res = av;
    endcase
  endfunction

  task automatic run8(input string tag, input int o, input int av, input int bv,
                      input longint er, input longint erem, input longint edz,
                      input int elat, input int hold);
    int lat;
    bit busy_ok;
    @(negedge clk);
    in_valid = 1'b1; op = 3'(o); a = 8'(av); b = 8'(bv); out_ready = 1'b0;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      busy_ok &= !in_ready;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, result, er);
    check({tag, " remainder"}, remainder, erem);
    check({tag, " dbz"}, div_by_zero, edz);
    for (int i = 0; i < hold; i++) begin
      busy_ok &= !in_ready;
      @(negedge clk);
      check({tag, " held result"}, result, er);
      check({tag, " held valid"}, out_valid, 1);
    end
    busy_ok &= !in_ready;
    check({tag, " busy"}, busy_ok, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " release"}, {out_valid, in_ready}, 2'b01);
  endtask

  // Random sweeps at other widths, started after the W=8 tests.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int GW = (gi == 0) ? 4 : 16;
    logic          iv, ir, ov, ordy, dz;
    logic [GW-1:0] ga, gb, grem;
    logic [2:0]    gop;
    logic [2*GW-1:0] gres;
    bit            done;

    seq_alu #(.W(GW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .op(gop), .out_valid(ov), .out_ready(ordy),
      .result(gres), .remainder(grem), .div_by_zero(dz)
    );

    initial begin
      iv = 1'b0; ordy = 1'b0; ga = '0; gb = '0; gop = '0; done = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < 40; n++) begin
        int o, av, bv, lat, elat;
        longint er, erem, edz;
        string tag;
        o  = $urandom_range(0, 7);
        av = $urandom_range(0, (1 << GW) - 1);
        bv = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, (1 << GW) - 1);
        model(GW, o, av, bv, er, erem, edz, elat);
        tag = $sformatf("W%0d op%0d a=%0d b=%0d", GW, o, av, bv);
        @(negedge clk);
        iv = 1'b1; gop = 3'(o); ga = GW'(av); gb = GW'(bv);
        for (int i = 0; i < 50 && !ir; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; ga = GW'($urandom); gb = GW'($urandom);
        lat = 1;
        while (!ov && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " result"}, gres, er);
        check({tag, " remainder"}, grem, erem);
        check({tag, " dbz"}, dz, edz);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    int nv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; sweep_go = 1'b0;
    #2;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run8("ADD 200+100", 0, 200, 100, 'h12C, 0, 0, 1, 0);
    run8("SUB 5-7",     1, 5, 7, 'h1FE, 0, 0, 1, 0);
    run8("SUB 7-5",     1, 7, 5, 'h002, 0, 0, 1, 0);
    run8("AND",         2, 'hF0, 'h3C, 'h30, 0, 0, 1, 0);
    run8("OR",          3, 'hF0, 'h0F, 'hFF, 0, 0, 1, 0);
    run8("XOR",         4, 'hAA, 'hFF, 'h55, 0, 0, 1, 0);
    run8("PASS",        7, 'h5A, 'hFF, 'h5A, 0, 0, 1, 0);
    run8("MUL 255*255", 5, 255, 255, 'hFE01, 0, 0, 9, 0);
    run8("DIV 200/7",   6, 200, 7, 28, 4, 0, 9, 0);
    run8("DIV 13/0",    6, 13, 0, 0, 13, 1, 1, 0);
    run8("MUL 12*11 held", 5, 12, 11, 132, 0, 0, 9, 5);

    // Back-to-back single-step ops with both handshakes held high.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; a = 8'd3; b = 8'd4; out_ready = 1'b1; nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("b2b throughput", nv, 10);
    check("b2b result", result, 7);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd6; a = 8'd200; b = 8'd7;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst result", result, 0);
    check("midrst remainder", remainder, 0);
    check("midrst dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst discarded", nv, 0);
    run8("ADD 1+1", 0, 1, 1, 2, 0, 0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      int o, av, bv, elat;
      longint er, erem, edz;
      o  = $urandom_range(0, 7);
      av = $urandom_range(0, 255);
      bv = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255);
      model(8, o, av, bv, er, erem, edz, elat);
      run8($sformatf("W8 op%0d a=%0d b=%0d", o, av, bv), o, av, bv, er, erem, edz, elat,
           $urandom_range(0, 2));
    end

    sweep_go = 1'b1;
    for (int i = 0; i < 20000 && !(g_sweep[0].done && g_sweep[1].done); i++) @(negedge clk);
    check("sweeps finished", {g_sweep[1].done, g_sweep[0].done}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
